// File: rtl/mips_mem_system.sv
// Unified memory port backend for the multicycle MIPS core: word RAM plus an
// MMIO window (GPIO, free-running timer with compare flag, 8N1 UART transmitter).
//
// UART FSM states
//   state | meaning
//   IDLE  | line high, ready to accept a byte
//   START | start bit (low) for CLK_DIV cycles
//   DATA  | 8 data bits LSB first, CLK_DIV cycles each
//   STOP  | stop bit (high) for CLK_DIV cycles
module mips_mem_system #(
  parameter int RAM_WORDS = 256,
  parameter int CLK_DIV   = 434
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  gpio_out,
  output logic        timer_irq,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [31:0]   ram [RAM_WORDS];
  logic          mmio_sel;
  logic [7:0]    offset;
  logic [AW-1:0] ram_idx;
  logic          wr_ram, wr_gpio, wr_count, wr_cmp, wr_status, wr_uart;

  logic [31:0]   timer_count, timer_cmp;
  logic          match_flag;

  uart_state_t   state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          uart_busy;

  assign mmio_sel  = (mem_addr[31:8] == 24'hFFFFFF);
  assign offset    = mem_addr[7:0];
  assign ram_idx   = mem_addr[AW+1:2];
  assign wr_ram    = mem_wr_ena && !mmio_sel;
  assign wr_gpio   = mem_wr_ena && mmio_sel && (offset == 8'h00);
  assign wr_count  = mem_wr_ena && mmio_sel && (offset == 8'h04);
  assign wr_cmp    = mem_wr_ena && mmio_sel && (offset == 8'h08);
  assign wr_status = mem_wr_ena && mmio_sel && (offset == 8'h0C);
  assign wr_uart   = mem_wr_ena && mmio_sel && (offset == 8'h10);
  assign uart_busy = (state_q != IDLE);

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= mem_wr_data;
  end

  // GPIO output register
  always_ff @(posedge clk) begin
    if (!rstb)        gpio_out <= 8'h00;
    else if (wr_gpio) gpio_out <= mem_wr_data[7:0];
  end

  // Timer: match compares the pre-update count, and a set beats a clear
  always_ff @(posedge clk) begin
    if (!rstb) begin
      timer_count <= 32'h0;
      timer_cmp   <= 32'hFFFF_FFFF;
      match_flag  <= 1'b0;
    end else begin
      timer_count <= wr_count ? mem_wr_data : timer_count + 32'd1;
      if (wr_cmp) timer_cmp <= mem_wr_data;
      if (timer_count == timer_cmp)          match_flag <= 1'b1;
      else if (wr_status && mem_wr_data[0]) match_flag <= 1'b0;
    end
  end

  assign timer_irq = match_flag;

  // UART state and datapath registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // UART next state; bit timer is a down-counter reloaded on each bit boundary
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: if (wr_uart) begin
        state_d   = START;
        bit_cnt_d = BIT_RELOAD;
        shift_d   = mem_wr_data[7:0];
      end
      START: if (bit_cnt_q == '0) begin
        state_d   = DATA;
        bit_cnt_d = BIT_RELOAD;
        bit_idx_d = 3'd0;
      end else bit_cnt_d = bit_cnt_q - 1'b1;
      DATA: if (bit_cnt_q == '0) begin
        bit_cnt_d = BIT_RELOAD;
        if (bit_idx_q == 3'd7) state_d = STOP;
        else bit_idx_d = bit_idx_q + 3'd1;
      end else bit_cnt_d = bit_cnt_q - 1'b1;
      STOP: if (bit_cnt_q == '0) state_d = IDLE;
      else bit_cnt_d = bit_cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_q;

  // Combinational read mux; reads must settle in the address cycle
  always_comb begin
    mem_rd_data = 32'h0;
    if (mmio_sel) begin
      case (offset)
        8'h00:   mem_rd_data = {24'h0, gpio_out};
        8'h04:   mem_rd_data = timer_count;
        8'h08:   mem_rd_data = timer_cmp;
        8'h0C:   mem_rd_data = {31'h0, match_flag};
        8'h14:   mem_rd_data = {31'h0, uart_busy};
        default: mem_rd_data = 32'h0;
      endcase
    end else begin
      mem_rd_data = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_mips_mem_system.sv
// Directed bench for mips_mem_system with a shortened UART bit time.
module tb_mips_mem_system;
  localparam int DIV = 4;

  logic        clk, rstb, mem_wr_ena, timer_irq, uart_tx;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [7:0]  gpio_out;

  int checks = 0;
  int errors = 0;

  mips_mem_system #(.RAM_WORDS(256), .CLK_DIV(DIV)) dut (
    .clk(clk), .rstb(rstb), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data), .gpio_out(gpio_out),
    .timer_irq(timer_irq), .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // one write: commits at the next rising edge, returns on the following negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wr_data = d; mem_wr_ena = 1'b1;
    @(negedge clk);
    mem_wr_ena = 1'b0;
  endtask

  // checks a 40-cycle frame starting in the cycle after the launch edge;
  // optionally pokes a dropped write at cycle 20
  task automatic run_frame(input logic [7:0] b, input bit poke);
    logic exp_tx;
    int   bitn;
    for (int i = 0; i < 10 * DIV; i++) begin
      bitn = i / DIV;
      if (bitn == 0)      exp_tx = 1'b0;
      else if (bitn == 9) exp_tx = 1'b1;
      else                exp_tx = b[bitn-1];
      mem_wr_data = 32'hFF;
      mem_wr_ena  = poke && (i == 20);
      mem_addr    = (poke && i == 20) ? 32'hFFFF_FF10 : 32'hFFFF_FF14;
      #1;
      check($sformatf("uart_tx[%0d]", i), {31'h0, uart_tx}, {31'h0, exp_tx});
      if (!(poke && i == 20)) check($sformatf("busy[%0d]", i), mem_rd_data, 32'h1);
      @(negedge clk);
    end
    mem_wr_ena = 1'b0;
  endtask

  vec_t vecs[$];
  int   wait_cnt;
  bit   tx_ok;

  initial begin
    vecs = '{
      '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0},
      '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF},
      '{32'h0000_0410, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF},
      '{32'h0000_0013, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF},
      '{32'h0000_0020, 1'b1, 32'h1234_5678, 1'b0, 32'h0},
      '{32'h0000_0820, 1'b0, 32'h0,         1'b1, 32'h1234_5678},
      '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF},
      '{32'hFFFF_FF00, 1'b1, 32'h0000_01A5, 1'b0, 32'h0},
      '{32'hFFFF_FF00, 1'b0, 32'h0,         1'b1, 32'h0000_00A5},
      '{32'hFFFF_FF08, 1'b1, 32'h8000_0000, 1'b0, 32'h0},
      '{32'hFFFF_FF08, 1'b0, 32'h0,         1'b1, 32'h8000_0000},
      '{32'hFFFF_FF10, 1'b0, 32'h0,         1'b1, 32'h0},
      '{32'hFFFF_FF40, 1'b1, 32'h0000_0123, 1'b0, 32'h0},
      '{32'hFFFF_FF40, 1'b0, 32'h0,         1'b1, 32'h0}
    };

    rstb = 1'b0; mem_wr_ena = 1'b0; mem_addr = 32'h0; mem_wr_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_addr = 32'hFFFF_FF00; #1 check("rst_gpio_rd", mem_rd_data, 32'h0);
    mem_addr = 32'hFFFF_FF08; #1 check("rst_cmp", mem_rd_data, 32'hFFFF_FFFF);
    mem_addr = 32'hFFFF_FF0C; #1 check("rst_status", mem_rd_data, 32'h0);
    mem_addr = 32'hFFFF_FF14; #1 check("rst_busy", mem_rd_data, 32'h0);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    rstb = 1'b1;
    mem_addr = 32'hFFFF_FF04; #1 check("rst_count", mem_rd_data, 32'h0);
    @(negedge clk);

    foreach (vecs[k]) begin
      mem_addr = vecs[k].addr; mem_wr_ena = vecs[k].we; mem_wr_data = vecs[k].wdata;
      #1;
      if (vecs[k].chk) check($sformatf("vec%0d_rd", k), mem_rd_data, vecs[k].exp_rd);
      @(negedge clk);
    end
    mem_wr_ena = 1'b0;
    check("gpio_out", {24'h0, gpio_out}, 32'h0000_00A5);

    // timer match latency
    wr(32'hFFFF_FF08, 32'd20);
    wr(32'hFFFF_FF0C, 32'h1);
    wr(32'hFFFF_FF04, 32'd10);
    mem_addr = 32'hFFFF_FF04; #1 check("count_load", mem_rd_data, 32'd10);
    check("irq_pre", {31'h0, timer_irq}, 32'h0);
    wait_cnt = 0;
    while (!timer_irq && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("irq_latency", wait_cnt, 32'd11);
    wr(32'hFFFF_FF0C, 32'h0);
    check("irq_w0_keeps", {31'h0, timer_irq}, 32'h1);
    wr(32'hFFFF_FF0C, 32'h1);
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);
    wr(32'hFFFF_FF04, 32'hFFFF_FFFF);
    mem_addr = 32'hFFFF_FF04; #1 check("count_max", mem_rd_data, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 check("count_wrap", mem_rd_data, 32'h0);
    // set beats clear on the same edge
    wr(32'hFFFF_FF08, 32'h100);
    wr(32'hFFFF_FF04, 32'h100);
    wr(32'hFFFF_FF0C, 32'h1);
    check("set_wins", {31'h0, timer_irq}, 32'h1);
    // count write on the match edge: flag sets, loaded value replaces increment
    wr(32'hFFFF_FF0C, 32'h1);
    wr(32'hFFFF_FF04, 32'h100);
    wr(32'hFFFF_FF04, 32'h500);
    mem_addr = 32'hFFFF_FF04; #1 check("load_on_match", mem_rd_data, 32'h500);
    check("match_old_count", {31'h0, timer_irq}, 32'h1);

    // UART frame with a dropped mid-frame write, then a back-to-back launch
    wr(32'hFFFF_FF10, 32'h55);
    run_frame(8'h55, 1'b1);
    mem_addr = 32'hFFFF_FF14; #1 check("idle_busy", mem_rd_data, 32'h0);
    check("idle_tx", {31'h0, uart_tx}, 32'h1);
    wr(32'hFFFF_FF10, 32'h0F);
    run_frame(8'h0F, 1'b0);

    // reset during DATA abandons the frame
    wr(32'hFFFF_FF10, 32'h00);
    repeat (12) @(negedge clk);
    check("mid_frame_tx", {31'h0, uart_tx}, 32'h0);
    rstb = 1'b0;
    @(negedge clk);
    mem_addr = 32'hFFFF_FF14; #1 check("rst_mid_busy", mem_rd_data, 32'h0);
    check("rst_mid_tx", {31'h0, uart_tx}, 32'h1);
    rstb = 1'b1;
    tx_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) tx_ok = 1'b0;
    end
    check("no_resume", {31'h0, tx_ok}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mem_system.md
# mips_mem_system

Memory and memory-mapped I/O subsystem on the downstream side of the multicycle MIPS core's unified memory port. It decodes each core access into either a word-addressed data/instruction RAM or a small MMIO register window. The window holds a GPIO output register, a free-running timer with compare interrupt, and an 8N1 UART transmitter. Reads are combinational, because the core latches read data on the same edge it presents the address. Writes commit on the rising clock edge.

## Interface
- RAM_WORDS, 256: RAM depth in 32-bit words; power of two.
- CLK_DIV, 434: clock cycles per UART bit; at least 2.
- clk  input  1  clock.
- rstb  input  1  synchronous, active-low reset.
- mem_addr  input  32  byte address from core; bits [1:0] ignored.
- mem_wr_data  input  32  write data from core.
- mem_wr_ena  input  1  write strobe; write commits at the rising edge.
- mem_rd_data  output  32  combinational read data for mem_addr.
- gpio_out  output  8  GPIO register value.
- timer_irq  output  1  timer match flag (level).
- uart_tx  output  1  serial line; idles high.

## Operation
- **Decode**
  - mem_addr[31:8] == 24'hFFFFFF selects MMIO, with register offset mem_addr[7:0].
  - Any other address selects RAM at word index mem_addr[log2(RAM_WORDS)+1:2]. Higher address bits alias, so the index wraps.
- **RAM**
  - Read is asynchronous.
  - A write occurs when mem_wr_ena is high and RAM is selected.
  - RAM is not cleared by reset.
- **MMIO map** (reads are zero-extended; unlisted offsets read 0 and ignore writes):
  - 0x00 GPIO: read/write, bits [7:0].
  - 0x04 TIMER_COUNT: read/write. Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0. A write loads the value instead of incrementing that cycle.
  - 0x08 TIMER_CMP: read/write.
  - 0x0C TIMER_STATUS: bit0 is a sticky match flag. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x10 UART_TX: write-only; reads return 0. A write while idle launches a frame with byte mem_wr_data[7:0]. A write while busy is dropped.
  - 0x14 UART_STATUS: bit0 = busy (state != IDLE).
- **Timer match**
  - At each edge where the current (pre-update) TIMER_COUNT equals TIMER_CMP, the flag is set.
  - If a set and a clear occur on the same edge, set wins.
  - timer_irq equals the flag.
- **UART FSM**: IDLE → START → DATA → STOP → IDLE.
  - Every state except IDLE holds for CLK_DIV cycles, timed by a bit counter.
  - DATA shifts out 8 bits, LSB first, using a 3-bit index.
  - uart_tx is registered: 1 in IDLE and STOP, 0 in START, the data bit in DATA.
  - A byte is latched into the shift register only on the launch edge.
- **Reset values**
  - gpio_out = 0.
  - TIMER_COUNT = 0.
  - TIMER_CMP = 0xFFFFFFFF.
  - Match flag = 0, so timer_irq = 0.
  - UART state = IDLE, so uart_tx = 1 and busy = 0.
  - Bit counter and shift register = 0.
  - mem_rd_data reflects these values combinationally.

## Timing
- **Read latency**: 0 cycles. mem_rd_data settles within the same cycle as mem_addr.
- **Write latency**: the new value is visible on reads and on gpio_out in the cycle after the write edge.
- **UART frame**
  - On the launch edge (write to 0x10 while IDLE), the state becomes START and uart_tx falls in the following cycle.
  - The frame lasts exactly 10·CLK_DIV cycles of uart_tx activity.
  - busy is high from the cycle after the launch edge through the last STOP cycle. It reads 0 in the first IDLE cycle.
  - A new write in that first IDLE cycle launches immediately (back-to-back frames).
- **Timer**
  - A flag set at edge N gives timer_irq = 1 in cycle N+1.
  - A clear write at edge N gives timer_irq = 0 in cycle N+1, unless a match also occurs at edge N.
- **Reset mid-operation**: at the first rstb-low edge, uart_tx returns to 1 and busy to 0. Any frame in flight is abandoned and not resumed.
- **Simultaneous events**
  - A write to TIMER_COUNT on the match edge: the match is evaluated on the old count and the loaded value replaces the increment.
  - Core writes have no other contention, since there is a single port.

## Test plan
- **Reset values**: hold rstb=0 for 2 cycles, then read 0x00/0x04/0x08/0x0C/0x14 → 0, 0, 0xFFFFFFFF, 0, 0; uart_tx=1; timer_irq=0.
- **RAM and aliasing** (RAM_WORDS=256)
  - Write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000410 → both return 0xDEADBEEF.
  - Read 0x00000013 → 0xDEADBEEF, because bits [1:0] are ignored.
- **GPIO**: write 0x1A5 to 0xFFFFFF00 → gpio_out=0xA5 in the next cycle; read returns 0x000000A5.
- **Timer match**
  - Write CMP=20, then COUNT=10 → timer_irq rises in the cycle after the count=20 edge, 11 cycles after the COUNT write edge.
  - Write 1 to 0x0C → irq drops next cycle.
  - Write COUNT=0xFFFFFFFF → the count wraps to 0 next cycle.
- **UART** (CLK_DIV=4)
  - Write 0x55 to 0x10 → uart_tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. busy=1 throughout the 40 cycles, then 0.
  - A second write (0xFF) mid-frame is ignored; a write in the first idle cycle launches immediately.
- **Reset mid-frame**: launch 0x00 and assert rstb=0 during the DATA state → uart_tx=1 and busy=0 after that edge. After release, no frame resumes.
